// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync + deglitch, deserialise start/8 data/odd parity/stop.
// Good bytes pulse dataout_valid one cycle after the stop-bit fall; bad frames or gaps pulse dataout_error and inhibit the clock.
module ps2_rx_frame #(
  parameter int CLK_FREQ   = 28000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 100,
  parameter int INHIBIT_US = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic [7:0] dataout,
  output logic       dataout_valid,
  output logic       dataout_error
);

  localparam int TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam int INHIBIT_CYC = CLK_FREQ / 1000000 * INHIBIT_US;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = $clog2(INHIBIT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    INHIBIT
  } state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_flt_q, clk_flt_d;
  logic          dat_flt_q, dat_flt_d;
  logic [FW-1:0] clk_fcnt_q, clk_fcnt_d;
  logic [FW-1:0] dat_fcnt_q, dat_fcnt_d;
  logic          clk_prev_q;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ok_q, ok_d;
  logic [TW-1:0] gap_q, gap_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [7:0]    dataout_q, dataout_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic          clk_out_q, clk_out_d;
  logic          gap_hit;

  // A filtered line only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_flt_d  = clk_flt_q;
    clk_fcnt_d = '0;
    dat_flt_d  = dat_flt_q;
    dat_fcnt_d = '0;
    if (clk_sync_q[1] != clk_flt_q) begin
      if (clk_fcnt_q == FW'(FILTER_LEN - 1)) begin
        clk_flt_d = clk_sync_q[1];
      end else begin
        clk_fcnt_d = clk_fcnt_q + FW'(1);
      end
    end
    if (dat_sync_q[1] != dat_flt_q) begin
      if (dat_fcnt_q == FW'(FILTER_LEN - 1)) begin
        dat_flt_d = dat_sync_q[1];
      end else begin
        dat_fcnt_d = dat_fcnt_q + FW'(1);
      end
    end
  end

  assign fall = clk_prev_q & ~clk_flt_q;

  // Gap counter is zero in the cycle after a fall, so this hit makes the error land TIMEOUT_CYC cycles after it.
  assign gap_hit = (gap_q == TW'(TIMEOUT_CYC - 2));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ok_d      = ok_q;
    gap_d     = '0;
    inh_d     = '0;
    dataout_d = dataout_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    clk_out_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (fall && !dat_flt_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          par_d     = 1'b0;
        end
      end
      DATA, PARITY, STOP: begin
        if (fall) begin
          unique case (state_q)
            DATA: begin
              shift_d   = {dat_flt_q, shift_q[7:1]};
              par_d     = par_q ^ dat_flt_q;
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_d = PARITY;
              end
            end
            PARITY: begin
              ok_d    = par_q ^ dat_flt_q;
              state_d = STOP;
            end
            default: begin
              if (dat_flt_q && ok_q) begin
                dataout_d = shift_q;
                valid_d   = 1'b1;
                state_d   = IDLE;
              end else begin
                error_d   = 1'b1;
                clk_out_d = 1'b0;
                state_d   = INHIBIT;
              end
            end
          endcase
        end else if (gap_hit) begin
          error_d   = 1'b1;
          clk_out_d = 1'b0;
          state_d   = INHIBIT;
        end else begin
          gap_d = gap_q + TW'(1);
        end
      end
      INHIBIT: begin
        if (inh_q == IW'(INHIBIT_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          clk_out_d = 1'b0;
          inh_d     = inh_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_flt_q  <= 1'b1;
      dat_flt_q  <= 1'b1;
      clk_fcnt_q <= '0;
      dat_fcnt_q <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ok_q       <= 1'b0;
      gap_q      <= '0;
      inh_q      <= '0;
      dataout_q  <= 8'h00;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      clk_out_q  <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      clk_flt_q  <= clk_flt_d;
      dat_flt_q  <= dat_flt_d;
      clk_fcnt_q <= clk_fcnt_d;
      dat_fcnt_q <= dat_fcnt_d;
      clk_prev_q <= clk_flt_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ok_q       <= ok_d;
      gap_q      <= gap_d;
      inh_q      <= inh_d;
      dataout_q  <= dataout_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign ps2_clk_out   = clk_out_q;
  assign ps2_dat_out   = 1'b1;
  assign dataout       = dataout_q;
  assign dataout_valid = valid_q;
  assign dataout_error = error_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame at 1 MHz, FILTER_LEN=2, 80-cycle PS/2 bit period.
// Raw-line edge to internal fall is 4 cycles (2 sync + 2 filter), so a pulse due one cycle after the fall shows 5 cycles after the raw edge.
module tb_ps2_rx_frame;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_line;
  logic       ps2_clk_out, ps2_dat_out;
  logic [7:0] dataout;
  logic       dataout_valid, dataout_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int vcnt = 0, ecnt = 0, both = 0;
  int vcyc = 0, ecyc = 0;
  int lowrun = 0, last_low = 0, lowtot = 0;
  logic [7:0] vq [$];
  int v0, e0, l0;
  logic [7:0] d0;

  // Open-drain wired-AND of device and host clock drivers.
  assign ps2_clk_line = dev_clk & ps2_clk_out;

  ps2_rx_frame #(
    .CLK_FREQ(1000000), .FILTER_LEN(2), .TIMEOUT_US(100), .INHIBIT_US(120)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_line), .ps2_dat_in(dev_dat),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out), .dataout(dataout),
    .dataout_valid(dataout_valid), .dataout_error(dataout_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (dataout_valid === 1'b1) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
      vq.push_back(dataout);
    end
    if (dataout_error === 1'b1) begin
      ecnt = ecnt + 1;
      ecyc = cyc;
    end
    if (dataout_valid === 1'b1 && dataout_error === 1'b1) both = both + 1;
    if (ps2_clk_out === 1'b0) begin
      lowrun = lowrun + 1;
      lowtot = lowtot + 1;
    end else if (lowrun != 0) begin
      last_low = lowrun;
      lowrun = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    dev_dat = v;
    if (glitch) begin
      repeat (20) @(negedge clk);
      dev_clk = 1'b0;
      @(negedge clk);
      dev_clk = 1'b1;
      repeat (19) @(negedge clk);
    end else begin
      repeat (40) @(negedge clk);
    end
    dev_clk = 1'b0;
    last_fall = cyc;
    repeat (40) @(negedge clk);
    dev_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic glitch);
    logic p;
    p = (~^b) ^ par_flip;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(p, glitch);
    send_bit(1'b1, glitch);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clk_out", 32'(ps2_clk_out), 32'h1);
    chk("rst_dat_out", 32'(ps2_dat_out), 32'h1);
    chk("rst_dataout", 32'(dataout), 32'h00);
    chk("rst_valid", 32'(dataout_valid), 32'h0);
    chk("rst_error", 32'(dataout_error), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b0);
    chk("1c_vcnt", 32'(vcnt), 32'd1);
    chk("1c_data", 32'(dataout), 32'h1C);
    chk("1c_lat", 32'(vcyc), 32'(last_fall + 5));
    chk("1c_ecnt", 32'(ecnt), 32'd0);

    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("b2b_vcnt", 32'(vcnt), 32'd4);
    chk("b2b_q1", 32'(vq[1]), 32'hF0);
    chk("b2b_q2", 32'(vq[2]), 32'hE0);
    chk("b2b_q3", 32'(vq[3]), 32'h75);

    send_frame(8'h1C, 1'b1, 1'b0);
    chk("par_ecnt", 32'(ecnt), 32'd1);
    chk("par_lat", 32'(ecyc), 32'(last_fall + 5));
    chk("par_keep", 32'(dataout), 32'h75);
    chk("par_vcnt", 32'(vcnt), 32'd4);
    repeat (200) @(negedge clk);
    chk("par_inhibit_len", 32'(last_low), 32'd120);
    send_frame(8'h33, 1'b0, 1'b0);
    chk("post_inh_vcnt", 32'(vcnt), 32'd5);
    chk("post_inh_data", 32'(dataout), 32'h33);

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    repeat (150) @(negedge clk);
    chk("to_ecnt", 32'(ecnt), 32'd2);
    chk("to_lat", 32'(ecyc), 32'(last_fall + 104));
    chk("to_vcnt", 32'(vcnt), 32'd5);
    repeat (200) @(negedge clk);
    chk("to_inhibit_len", 32'(last_low), 32'd120);

    send_frame(8'hA5, 1'b0, 1'b1);
    chk("glitch_vcnt", 32'(vcnt), 32'd6);
    chk("glitch_data", 32'(dataout), 32'hA5);
    chk("glitch_ecnt", 32'(ecnt), 32'd2);

    v0 = vcnt; e0 = ecnt; l0 = lowtot; d0 = dataout;
    send_bit(1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("badstart_vcnt", 32'(vcnt), 32'(v0));
    chk("badstart_ecnt", 32'(ecnt), 32'(e0));
    chk("badstart_low", 32'(lowtot), 32'(l0));
    chk("badstart_data", 32'(dataout), 32'(d0));

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(8'h5A >> i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", 32'(dataout), 32'h00);
    repeat (200) @(negedge clk);
    chk("midrst_ecnt", 32'(ecnt), 32'(e0));
    chk("midrst_vcnt", 32'(vcnt), 32'(v0));
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("5a_vcnt", 32'(vcnt), 32'(v0 + 1));
    chk("5a_data", 32'(dataout), 32'h5A);
    chk("never_both", 32'(both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
